signed_subtractor: RTL and testbench

//  Two's-complement signed subtractor: out = a - b, plus a signed-overflow flag.

---
 rtl/signed_subtractor_if.sv | 26 ++
 rtl/signed_subtractor.sv | 43 ++++
 tb/tb_signed_subtractor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/signed_subtractor_if.sv
// Operand/result bundle of the signed subtractor: the master supplies a/b,
// the slave returns the registered difference and its overflow flag.
interface signed_subtractor_if #(
  parameter int WIDTH = 6
);
  // No valid/ready: a new a/b pair is taken on every rising clk edge,
  // and out/overflow describe the pair sampled on the previous edge.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             overflow;

  modport master (
    output a,
    output b,
    input  out,
    input  overflow
  );

  modport slave (
    input  a,
    input  b,
    output out,
    output overflow
  );
endinterface

// File: rtl/signed_subtractor.sv
// Registered two's-complement subtractor: out = a - b (mod 2^WIDTH) built as
// a ripple-borrow chain a + ~b + 1, with a registered signed-overflow flag.
module signed_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  signed_subtractor_if.slave sub
);

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;
  logic             ovf_comb;
  logic [WIDTH-1:0] out_q;
  logic             overflow_q;

  assign b_inv    = ~sub.b;
  // The +1 of the two's-complement negation enters as the chain's carry-in.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i]    = sub.a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (sub.a[i] & b_inv[i]) | (carry[i] & (sub.a[i] ^ b_inv[i]));
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= diff;
      overflow_q <= ovf_comb;
    end
  end

  assign sub.out      = out_q;
  assign sub.overflow = overflow_q;

endmodule

// File: tb/tb_signed_subtractor.sv
// Self-checking bench for signed_subtractor: directed vector table, exhaustive
// pipelined sweep with a mid-sweep async reset, and random pairs vs. a model.
`timescale 1ns/1ps
module tb_signed_subtractor;

  localparam int WIDTH = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // {overflow, out} expected for each pair in flight
  logic [WIDTH:0] exp_q[$];

  signed_subtractor_if #(.WIDTH(WIDTH)) bus ();

  signed_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Exact integer difference, then range test and wrap to WIDTH bits.
  function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    int sa, sb, d;
    logic ov;
    logic [WIDTH-1:0] wrapped;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = sa - sb;
    ov = (d < -(1 << (WIDTH-1))) || (d > (1 << (WIDTH-1)) - 1);
    wrapped = WIDTH'(d);
    return {ov, wrapped};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [WIDTH:0] exp);
    check({name, ".out"},      int'(bus.out),      int'(exp[WIDTH-1:0]));
    check({name, ".overflow"}, int'(bus.overflow), int'(exp[WIDTH]));
  endtask

  // ---------------- driver tasks ----------------
  // Single operation: drive on the falling edge, check just after the next rise.
  task automatic apply_one(input string name, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH:0] exp);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    check_outputs(name, exp);
  endtask

  // Back-to-back stream: each falling edge checks the previous pair and drives a new one.
  task automatic stream_pair(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_outputs(name, e);
    end
    bus.a = a;
    bus.b = b;
    exp_q.push_back(ref_model(a, b));
  endtask

  task automatic drain(input string name);
    logic [WIDTH:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_outputs(name, e);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_out;
    logic             exp_ov;
  } vec_t;

  vec_t vecs[10];

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{a: 6'd5,    b: 6'd3,    exp_out: 6'd2,    exp_ov: 1'b0}; //  5 - 3
    vecs[1] = '{a: 6'h20,   b: 6'd1,    exp_out: 6'd31,   exp_ov: 1'b1}; // -32 - 1
    vecs[2] = '{a: 6'd31,   b: 6'h3f,   exp_out: 6'h20,   exp_ov: 1'b1}; //  31 - (-1)
    vecs[3] = '{a: 6'h20,   b: 6'h20,   exp_out: 6'd0,    exp_ov: 1'b0}; // -32 - (-32)
    vecs[4] = '{a: 6'd0,    b: 6'h20,   exp_out: 6'h20,   exp_ov: 1'b1}; //  0 - (-32)
    vecs[5] = '{a: 6'h3f,   b: 6'd31,   exp_out: 6'h20,   exp_ov: 1'b0}; // -1 - 31 = -32
    vecs[6] = '{a: 6'h3f,   b: 6'h20,   exp_out: 6'd31,   exp_ov: 1'b0}; // -1 - (-32) = 31
    vecs[7] = '{a: 6'd10,   b: 6'h2a,   exp_out: 6'h20,   exp_ov: 1'b1}; //  10 - (-22) = 32
    vecs[8] = '{a: 6'd17,   b: 6'd17,   exp_out: 6'd0,    exp_ov: 1'b0}; //  a == b
    vecs[9] = '{a: 6'h2b,   b: 6'd24,   exp_out: 6'h13,   exp_ov: 1'b0}; // -21 - 24 = -45 -> wraps? see below

    // -21 - 24 = -45 is out of range: wrapped 19, overflow set.
    vecs[9].exp_ov = 1'b1;

    // ---- reset behaviour ----
    rst_n = 1'b0;
    bus.a = 6'd9;
    bus.b = 6'd2;
    #1;
    check_outputs("reset_async", {1'b0, 6'd0});
    @(posedge clk);
    #1;
    check_outputs("reset_held_through_edge", {1'b0, 6'd0});
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset_release_before_edge", {1'b0, 6'd0});
    @(posedge clk);
    #1;
    check_outputs("first_edge_after_reset", {1'b0, 6'd7});

    // ---- directed table ----
    for (int i = 0; i < 10; i++) begin
      apply_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                {vecs[i].exp_ov, vecs[i].exp_out});
    end

    // ---- exhaustive sweep, first half ----
    for (int i = 0; i < 2048; i++) begin
      stream_pair($sformatf("sweep_a%0d_b%0d", i / 64, i % 64),
                  WIDTH'(i / 64), WIDTH'(i % 64));
    end
    drain("sweep_lo_drain");

    // ---- async reset asserted between edges with a result in flight ----
    @(negedge clk);
    bus.a = 6'd13;
    bus.b = 6'h2c; // -20: 13 - (-20) = 33 -> overflow, wrapped -31
    @(posedge clk);
    #1;
    check_outputs("pre_reset_result", ref_model(6'd13, 6'h2c));
    #1 rst_n = 1'b0;
    #1;
    check_outputs("midsweep_reset_async", {1'b0, 6'd0});
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs("midsweep_reset_hold", {1'b0, 6'd0});
    @(posedge clk);
    #1;
    check_outputs("midsweep_post_release", ref_model(6'd13, 6'h2c));

    // ---- exhaustive sweep, second half ----
    for (int i = 2048; i < 4096; i++) begin
      stream_pair($sformatf("sweep_a%0d_b%0d", i / 64, i % 64),
                  WIDTH'(i / 64), WIDTH'(i % 64));
    end
    drain("sweep_hi_drain");

    // ---- random back-to-back pairs ----
    for (int i = 0; i < 300; i++) begin
      stream_pair($sformatf("rand%0d", i),
                  WIDTH'($urandom_range(0, 63)), WIDTH'($urandom_range(0, 63)));
    end
    drain("rand_drain");

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
